adc_sample_fifo: RTL

Sample buffer directly downstream of the ADC serial controller, on the `sclk` domain. It accepts each completed 16-bit conversion word (channel in [15:13], result in [11:0]) and filters it by a per-channel enable mask. Accepted words go into a FIFO that the EBI side drains through a small register window at `POSITION << 8`. The FIFO also tracks overflow and the number of dropped samples, so software can detect lost data.

---
 rtl/adc_sample_fifo.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/adc_sample_fifo.sv
// ============================================================================
// Module      : adc_sample_fifo
// Description : Channel-filtered sample FIFO with overflow/drop tracking and
//               a four-register read/control window at POSITION << 8.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module adc_sample_fifo #(
    parameter int POSITION   = 1,
    parameter int DEPTH_LOG2 = 6
) (
    input  logic        sclk,
    input  logic        reset,
    input  logic [15:0] sample_in,
    input  logic        sample_valid,
    input  logic [18:0] addr,
    input  logic [15:0] data_in,
    input  logic        wr,
    input  logic        rd,
    output logic [15:0] data_out,
    output logic        empty,
    output logic        full,
    output logic        overflow
);

    localparam int              c_PW       = DEPTH_LOG2 + 1;
    localparam int              c_DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [18:0]     c_BASE     = 19'(POSITION << 8);
    localparam logic [18:0]     c_A_CTRL   = c_BASE;
    localparam logic [18:0]     c_A_STATUS = c_BASE + 19'd1;
    localparam logic [18:0]     c_A_DATA   = c_BASE + 19'd2;
    localparam logic [18:0]     c_A_DROPS  = c_BASE + 19'd3;
    localparam logic [c_PW-1:0] c_FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [15:0]     r_mem [c_DEPTH];
    logic [c_PW-1:0] r_wptr;
    logic [c_PW-1:0] r_rptr;
    logic            r_empty;
    logic            r_full;
    logic            r_overflow;
    logic [7:0]      r_drop_cnt;
    logic [7:0]      r_mask;
    logic [15:0]     r_data_out;

    logic            w_sel_ctrl;
    logic            w_sel_status;
    logic            w_sel_data;
    logic            w_sel_drops;
    logic            w_wr_ctrl;
    logic            w_flush;
    logic            w_clear;
    logic            w_accept;
    logic            w_pop;
    logic            w_push;
    logic            w_drop;
    logic [c_PW-1:0] w_count;
    logic [c_PW-1:0] w_wptr_nxt;
    logic [c_PW-1:0] w_rptr_nxt;
    logic [c_PW-1:0] w_count_nxt;
    logic [12:0]     w_count_ext;
    logic [15:0]     w_rd_mux;
    logic            w_unused;

    assign w_sel_ctrl   = (addr == c_A_CTRL);
    assign w_sel_status = (addr == c_A_STATUS);
    assign w_sel_data   = (addr == c_A_DATA);
    assign w_sel_drops  = (addr == c_A_DROPS);

    assign w_wr_ctrl = wr & w_sel_ctrl;
    assign w_flush   = w_wr_ctrl & data_in[0];
    assign w_clear   = w_wr_ctrl & data_in[1];
    assign w_unused  = ^data_in[7:2];

    // Mask filtering uses the registered mask, so a CTRL write only affects
    // pushes from the following cycle onward.
    assign w_accept = sample_valid & r_mask[sample_in[15:13]] & ~w_flush;
    assign w_pop    = rd & w_sel_data & ~r_empty & ~w_flush;
    assign w_push   = w_accept & (~r_full | w_pop);
    assign w_drop   = w_accept & r_full & ~w_pop;

    assign w_count     = r_wptr - r_rptr;
    assign w_count_ext = 13'(w_count);

    always_comb begin
        w_wptr_nxt = r_wptr;
        w_rptr_nxt = r_rptr;
        if (w_flush) begin
            w_wptr_nxt = '0;
            w_rptr_nxt = '0;
        end else begin
            if (w_push) begin
                w_wptr_nxt = r_wptr + 1'b1;
            end
            if (w_pop) begin
                w_rptr_nxt = r_rptr + 1'b1;
            end
        end
        w_count_nxt = w_wptr_nxt - w_rptr_nxt;
    end

    always_comb begin
        w_rd_mux = 16'h0000;
        if (w_sel_ctrl) begin
            w_rd_mux = {r_mask, 8'h00};
        end else if (w_sel_status) begin
            w_rd_mux = {r_overflow, r_full, r_empty, w_count_ext};
        end else if (w_sel_data) begin
            w_rd_mux = w_pop ? r_mem[r_rptr[DEPTH_LOG2-1:0]] : 16'h0000;
        end else if (w_sel_drops) begin
            w_rd_mux = {8'h00, r_drop_cnt};
        end
    end

    // Storage array: no reset, contents are never observable before a push.
    // When full, a same-cycle push and pop hit the same slot; the read above
    // sees the old (head) word because the write lands at the clock edge.
    always_ff @(posedge sclk) begin
        if (w_push) begin
            r_mem[r_wptr[DEPTH_LOG2-1:0]] <= sample_in;
        end
    end

    always_ff @(posedge sclk) begin
        if (reset) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_empty    <= 1'b1;
            r_full     <= 1'b0;
            r_overflow <= 1'b0;
            r_drop_cnt <= 8'h00;
            r_mask     <= 8'hFF;
            r_data_out <= 16'h0000;
        end else begin
            r_wptr  <= w_wptr_nxt;
            r_rptr  <= w_rptr_nxt;
            r_empty <= (w_count_nxt == '0);
            r_full  <= (w_count_nxt == c_FULL_CNT);
            if (w_clear) begin
                r_overflow <= 1'b0;
                r_drop_cnt <= 8'h00;
            end else if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_cnt != 8'hFF) begin
                    r_drop_cnt <= r_drop_cnt + 8'd1;
                end
            end
            if (w_wr_ctrl) begin
                r_mask <= data_in[15:8];
            end
            if (rd) begin
                r_data_out <= w_rd_mux;
            end
        end
    end

    assign data_out = r_data_out;
    assign empty    = r_empty;
    assign full     = r_full;
    assign overflow = r_overflow;

endmodule

`default_nettype wire
